// File: rtl/onehot_scan_decoder_if.sv
// Bus between a select-line consumer and the one-hot scan decoder.
// The master drives control/address; the slave (decoder) returns the select lines and index.
interface onehot_scan_decoder_if #(
  parameter int N = 2
);
  logic                ena;
  logic                mode;
  logic                load;
  logic [N-1:0]        addr;
  logic [N-1:0]        last;
  logic [(1<<N)-1:0]   out;
  logic [N-1:0]        index;
  logic                wrap;

  modport master (
    output ena, mode, load, addr, last,
    input  out, index, wrap
  );

  modport slave (
    input  ena, mode, load, addr, last,
    output out, index, wrap
  );
endinterface

// File: rtl/onehot_scan_decoder.sv
// N-to-2^N one-hot decoder with a registered index, direct load and a dwell-timed
// auto-advancing scan that pulses wrap whenever the index returns to 0.
module onehot_scan_decoder #(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_scan_decoder_if.slave  bus
);

  localparam int W  = 1 << N;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  logic [N-1:0]  index_q, index_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          en_r;
  logic [N-1:0]  load_val;

  assign load_val = (bus.addr > bus.last) ? bus.last : bus.addr;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    index_d = index_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      index_d = load_val;
      cnt_d   = '0;
    end else if (!bus.mode) begin
      cnt_d = '0;
    end else if (bus.ena) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
        // >= rather than == so an index stranded above a lowered last still wraps
        if (index_q >= bus.last) begin
          index_d = '0;
          wrap_d  = 1'b1;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_q <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      en_r    <= 1'b0;
    end else begin
      index_q <= index_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      en_r    <= bus.ena;
    end
  end

  assign bus.out   = en_r ? (W'(1) << index_q) : '0;
  assign bus.index = index_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
- Parametrised N-to-2^N one-hot decoder with enable, extended with a registered index and an auto-advancing scan mode.
- Drives row/column select lines for the game-of-life display and cell-update sweep.
- Direct mode: decodes a loaded address.
- Scan mode: steps the active line 0..last, holding each line for DWELL cycles, and flags each wrap.

Parameters:
- N, 2, address width; decoder drives 2**N output lines.
- DWELL, 4, cycles each line stays active in scan mode; legal range 1..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ena  input  1  output enable and scan run/pause.
- mode  input  1  0 = direct, 1 = scan.
- load  input  1  load addr into index this cycle.
- addr  input  N  address for load.
- last  input  N  highest index visited in scan mode; also clamps loads.
- out  output  2**N  one-hot select; all zero when disabled.
- index  output  N  current registered index.
- wrap  output  1  one-cycle pulse when scan wraps last -> 0.

Behaviour:
- State registers: index (N bits), en_r (1 bit), dwell counter cnt (width clog2(DWELL), min 1 bit), wrap (1 bit).
- Reset (async, immediate, no clock needed): index=0, en_r=0, cnt=0, wrap=0; hence out=0.
- en_r <= ena every cycle.
- out = en_r ? (1 << index) : 0. Decoded from registers only.
  - Latency: a change on ena, load or addr is visible on out one cycle later.
  - Exactly one bit is set when en_r=1; all bits clear when en_r=0.
- Clamp rule: loaded value = (addr > last) ? last : addr.
- Priority, highest first: rst > load > scan advance > hold.
- load=1 (either mode, regardless of ena): index <= clamp(addr); cnt <= 0; wrap <= 0.
- Direct mode (mode=0, load=0): index holds; cnt <= 0; wrap <= 0.
- Scan mode (mode=1, load=0):
  - ena=0: pause. index and cnt hold; wrap <= 0.
  - ena=1 and cnt < DWELL-1: cnt <= cnt+1; wrap <= 0.
  - ena=1 and cnt == DWELL-1: cnt <= 0, then one of:
    - index >= last: index <= 0; wrap <= 1.
    - otherwise: index <= index+1; wrap <= 0.
- wrap is high for exactly the cycle in which index first reads 0 after the wrap.
- DWELL=1: cnt is effectively constant 0; index advances every enabled cycle.
- last lowered below the current index: index holds until the next advance point, then wraps to 0 with a wrap pulse.
- last=0: index stays 0; wrap pulses every DWELL enabled cycles.
- Mode 1 -> 0 clears cnt. Scanning after re-entry to mode 1 starts a fresh dwell period from the held index.
- Pausing via ena=0 mid-dwell preserves cnt; on resume the remaining dwell cycles complete before the advance.
- index never exceeds max(last, the value at the moment last was lowered). No arithmetic overflow: the wrap compare uses >=.
- Reset asserted mid-scan: out, index and wrap go to 0 immediately. After release, scanning restarts from index 0 with cnt=0.

Test Plan:
- Truth table (N=2, mode=0): ena=0, load addr 0..3 -> out=0000 for every addr. ena=1, load addr 0..3 -> out=0001,0010,0100,1000, each one cycle after the load.
- Scan wrap (N=2, DWELL=3, last=3, mode=1, ena=1 held) -> index sequence 0,1,2,3,0, each held 3 cycles. wrap=1 only in the first cycle index returns to 0, once per 12 cycles.
- Partial scan and clamp (last=2) -> index 0,1,2,0 with a wrap pulse every 9 cycles. Load addr=3 -> index=2, out=0100 next cycle.
- Pause and precedence:
  - Drop ena for 5 cycles after 1 dwell cycle -> out=0000, index frozen. After re-enable, advance occurs 2 cycles later.
  - load addr=1 in the same cycle as a scheduled advance -> index=1, cnt=0, no wrap.
- Async reset: assert rst between clock edges mid-scan at index=2 -> out=0000 and index=0 before the next edge. After release, wrap stays 0 and scan resumes from 0.
- Parameter sweep: N=3, DWELL=1, last=7 -> out walks 00000001..10000000, one step per cycle. wrap pulses every 8 cycles. $onehot0(out) holds on every cycle.
